// File: rtl/tt6_uart_tx.sv
// FIFO-buffered 8N1 UART transmitter for the experiment-six core's output bytes.
// Each byte accepted on din is sent LSB first on tx. Each bit is held for CLK_DIV clock cycles.
module tt6_uart_tx #(
    parameter int CLK_DIV = 104,
    parameter int DEPTH   = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     ena,
    input  logic [7:0]               din,
    input  logic                     din_valid,
    output logic                     din_ready,
    output logic                     tx,
    output logic                     tx_oe,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   level,
    output logic [1:0]               fsm_state
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;
    localparam int TW = $clog2(CLK_DIV);
    localparam logic [TW-1:0] TIMER_MAX = TW'(CLK_DIV - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t          state, state_next;
    logic [TW-1:0]   timer, timer_next;
    logic [2:0]      bit_idx, bit_next;
    logic [7:0]      shreg, shreg_next;
    logic            tx_q, tx_next;
    logic            pop, push, full, can_pop, bit_end;

    logic [7:0]      mem [DEPTH];
    logic [PW-1:0]   wr_ptr, rd_ptr;

    // Handshake: a byte transfers on a rising edge where din_valid && din_ready.
    // din_ready depends only on level, so it never depends on din_valid.
    assign full      = (level == LW'(DEPTH));
    assign din_ready = !full;
    assign push      = din_valid && din_ready;
    assign can_pop   = ena && (level != '0);
    assign bit_end   = (timer == TIMER_MAX);

    assign tx        = tx_q;
    assign tx_oe     = 1'b1;
    assign busy      = (state != IDLE);
    assign fsm_state = state;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            timer   <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            tx_q    <= 1'b1;
        end else begin
            state   <= state_next;
            timer   <= timer_next;
            bit_idx <= bit_next;
            shreg   <= shreg_next;
            tx_q    <= tx_next;
        end
    end

    // tx_next holds the level of the bit that starts on this edge.
    // That keeps tx registered and still aligned to the bit boundary.
    always_comb begin
        state_next = state;
        timer_next = timer + TW'(1);
        bit_next   = bit_idx;
        shreg_next = shreg;
        tx_next    = tx_q;
        pop        = 1'b0;
        case (state)
            IDLE: begin
                timer_next = '0;
                tx_next    = 1'b1;
                if (can_pop) begin
                    pop        = 1'b1;
                    shreg_next = mem[rd_ptr];
                    state_next = START;
                    tx_next    = 1'b0;
                end
            end
            START: begin
                if (bit_end) begin
                    timer_next = '0;
                    bit_next   = '0;
                    state_next = DATA;
                    tx_next    = shreg[0];
                end
            end
            DATA: begin
                if (bit_end) begin
                    timer_next = '0;
                    shreg_next = shreg >> 1;
                    if (bit_idx == 3'd7) begin
                        state_next = STOP;
                        tx_next    = 1'b1;
                    end else begin
                        bit_next = bit_idx + 3'd1;
                        tx_next  = shreg[1];
                    end
                end
            end
            STOP: begin
                if (bit_end) begin
                    timer_next = '0;
                    if (can_pop) begin
                        pop        = 1'b1;
                        shreg_next = mem[rd_ptr];
                        state_next = START;
                        tx_next    = 1'b0;
                    end else begin
                        state_next = IDLE;
                        tx_next    = 1'b1;
                    end
                end
            end
            default: begin
                state_next = IDLE;
                tx_next    = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_tt6_uart_tx.sv
// Testbench for tt6_uart_tx with CLK_DIV=4 and DEPTH=4: directed phases check the line cycle by cycle.
// A monitor decodes every frame on tx and compares it against a queue of expected bytes.
module tb_tt6_uart_tx;

    localparam int CLK_DIV = 4;
    localparam int DEPTH   = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ena = 1'b0;
    logic [7:0] din = 8'h00;
    logic       din_valid = 1'b0;
    logic       din_ready, tx, tx_oe, busy;
    logic [2:0] level;
    logic [1:0] fsm_state;

    int checks = 0;
    int failures = 0;
    int max_level = 0;
    logic [7:0] exp_q[$];

    tt6_uart_tx #(.CLK_DIV(CLK_DIV), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .ena(ena), .din(din), .din_valid(din_valid),
        .din_ready(din_ready), .tx(tx), .tx_oe(tx_oe), .busy(busy),
        .level(level), .fsm_state(fsm_state)
    );

    // ---------------- clock/reset ----------------
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [9:0] frame_of(input logic [7:0] b);
        return {1'b1, b, 1'b0};
    endfunction

    task automatic idle_chk(input string name, input int exp_level);
        chk({name, "_tx"}, tx, 1);
        chk({name, "_busy"}, busy, 0);
        chk({name, "_level"}, level, exp_level);
    endtask

    // Checks tx and busy on every cycle of n contiguous frames, starting one negedge after the call.
    task automatic watch_frames(input int n, input logic [9:0] p0, input logic [9:0] p1,
                                input logic [9:0] p2, input logic [9:0] p3, input int first_level);
        logic [9:0] pats [4];
        logic [9:0] fr;
        pats[0] = p0; pats[1] = p1; pats[2] = p2; pats[3] = p3;
        for (int c = 0; c < 40 * n; c++) begin
            @(negedge clk);
            fr = pats[c / 40];
            chk("frame_tx", tx, fr[(c % 40) / 4]);
            chk("frame_busy", busy, 1);
            if (c == 0 && first_level >= 0) chk("frame_first_level", level, first_level);
            if (int'(level) > max_level) max_level = int'(level);
        end
    endtask

    task automatic wait_neg(input int n, inout logic ok);
        repeat (n) begin
            @(negedge clk);
            if (rst) ok = 1'b0;
        end
    endtask

    // ---------------- scoreboard monitor ----------------
    initial begin : monitor
        logic       ok;
        logic       st, sp;
        logic [7:0] got;
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (!rst && tx === 1'b0) begin
                ok = 1'b1;
                got = '0;
                wait_neg(2, ok);
                st = tx;
                for (int b = 0; b < 8; b++) begin
                    wait_neg(4, ok);
                    got[b] = tx;
                end
                wait_neg(4, ok);
                sp = tx;
                if (ok) begin
                    chk("mon_start", st, 0);
                    chk("mon_stop", sp, 1);
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL mon_unexpected actual=%0h required=none", got);
                    end else begin
                        e = exp_q.pop_front();
                        chk("mon_byte", got, e);
                    end
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin : stim
        // Reset with random inputs
        repeat (5) begin
            @(negedge clk);
            din       = 8'($urandom_range(0, 255));
            din_valid = 1'($urandom_range(0, 1));
            ena       = 1'($urandom_range(0, 1));
            #1;
            idle_chk("rst", 0);
            chk("rst_ready", din_ready, 1);
            chk("rst_oe", tx_oe, 1);
            chk("rst_state", fsm_state, 0);
        end
        @(negedge clk);
        din_valid = 1'b0;
        ena = 1'b1;
        rst = 1'b0;
        #1;
        idle_chk("rel", 0);
        chk("rel_ready", din_ready, 1);
        chk("rel_oe", tx_oe, 1);
        @(negedge clk);
        idle_chk("rel2", 0);

        // Single byte 0xA5
        din = 8'hA5;
        din_valid = 1'b1;
        exp_q.push_back(8'hA5);
        @(negedge clk);
        din_valid = 1'b0;
        idle_chk("single_e0", 1);
        watch_frames(1, 10'b1101001010, 10'b0, 10'b0, 10'b0, 0);
        @(negedge clk);
        idle_chk("single_end", 0);

        // Back-to-back 01, 80, FF, 00
        max_level = 0;
        din = 8'h01;
        din_valid = 1'b1;
        exp_q.push_back(8'h01); exp_q.push_back(8'h80);
        exp_q.push_back(8'hFF); exp_q.push_back(8'h00);
        fork
            begin
                @(negedge clk); din = 8'h80;
                @(negedge clk); din = 8'hFF;
                @(negedge clk); din = 8'h00;
                @(negedge clk); din_valid = 1'b0;
            end
            begin
                @(negedge clk);
                watch_frames(4, 10'b1000000010, 10'b1100000000, 10'b1111111110, 10'b1000000000, 1);
            end
        join
        chk("b2b_peak_level", max_level, 3);
        @(negedge clk);
        idle_chk("b2b_end", 0);

        // Overflow with ena low
        ena = 1'b0;
        for (int i = 0; i < 6; i++) begin
            din = 8'h10 + 8'(i);
            din_valid = 1'b1;
            if (i < 4) exp_q.push_back(8'h10 + 8'(i));
            @(negedge clk);
            chk("ovf_level", level, (i < 4) ? i + 1 : 4);
            chk("ovf_ready", din_ready, (i < 3) ? 1 : 0);
            chk("ovf_tx", tx, 1);
            chk("ovf_busy", busy, 0);
        end
        din_valid = 1'b0;
        ena = 1'b1;
        watch_frames(4, frame_of(8'h10), frame_of(8'h11), frame_of(8'h12), frame_of(8'h13), 3);
        @(negedge clk);
        idle_chk("ovf_end", 0);

        // Enable gating with a second byte queued
        din = 8'h3C;
        din_valid = 1'b1;
        exp_q.push_back(8'h3C);
        exp_q.push_back(8'hC3);
        @(negedge clk);
        din = 8'hC3;
        fork
            begin
                @(negedge clk);
                din_valid = 1'b0;
                repeat (9) @(negedge clk);
                ena = 1'b0;
            end
            watch_frames(1, frame_of(8'h3C), 10'b0, 10'b0, 10'b0, 1);
        join
        repeat (5) begin
            @(negedge clk);
            idle_chk("gate_hold", 1);
        end
        ena = 1'b1;
        watch_frames(1, frame_of(8'hC3), 10'b0, 10'b0, 10'b0, 0);
        @(negedge clk);
        idle_chk("gate_end", 0);

        // Reset during bit 3 with two bytes queued
        din = 8'h55;
        din_valid = 1'b1;
        @(negedge clk); din = 8'h66;
        @(negedge clk); din = 8'h77;
        @(negedge clk); din_valid = 1'b0;
        chk("mid_level", level, 2);
        repeat (16) @(negedge clk);
        chk("mid_bit3", tx, 0);
        exp_q.delete();
        rst = 1'b1;
        #1;
        idle_chk("mid_async", 0);
        chk("mid_ready", din_ready, 1);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (60) begin
            @(negedge clk);
            idle_chk("mid_quiet", 0);
        end
        din = 8'h9A;
        din_valid = 1'b1;
        exp_q.push_back(8'h9A);
        @(negedge clk);
        din_valid = 1'b0;
        watch_frames(1, frame_of(8'h9A), 10'b0, 10'b0, 10'b0, 0);
        @(negedge clk);
        idle_chk("final", 0);

        repeat (2) @(negedge clk);
        chk("exp_q_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
